// File: rtl/button_press_classifier.sv
// button_press_classifier
// Classifies each debounced button press as short or long and, while a long
// press is held, emits periodic auto-repeat pulses. Inputs are one-cycle
// press/release pulses from the upstream debouncer; all outputs are registered.

module button_press_classifier #(
  parameter int LONG_CYCLES   = 100000000,  // hold time for a long press (1 s at 100 MHz)
  parameter int REPEAT_PERIOD = 20000000,   // auto-repeat spacing once long (200 ms)
  parameter int CNT_W         = 27          // holds max(LONG_CYCLES, REPEAT_PERIOD)-1
) (
  input  logic clk,
  input  logic resetN,
  input  logic pressPulse,
  input  logic releasePulse,
  input  logic repeatEnable,
  output logic shortPress,
  output logic longPress,
  output logic repeatPulse,
  output logic held
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_REPEAT  = 2'd2
  } state_t;

  // Terminal counts: the counter runs 0..N-1, so the event fires on the Nth
  // edge after entering the state.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_PERIOD - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_short;
  logic             r_long;
  logic             r_repeat;
  logic             r_held;

  state_t           w_next_state;
  logic [CNT_W-1:0] w_next_count;
  logic             w_next_short;
  logic             w_next_long;
  logic             w_next_repeat;
  logic             w_next_held;

  logic             w_at_long;
  logic             w_at_repeat;

  assign w_at_long   = (r_count == LONG_LAST);
  assign w_at_repeat = (r_count == REPEAT_LAST);

  // State, counter and output registers; reset discards any press in progress.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      r_held   <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_count  <= w_next_count;
      r_short  <= w_next_short;
      r_long   <= w_next_long;
      r_repeat <= w_next_repeat;
      r_held   <= w_next_held;
    end
  end

  // Next-state and counter: release beats the threshold, press is only
  // meaningful in IDLE (and beats a simultaneous release there).
  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    unique case (r_state)
      ST_IDLE: begin
        w_next_count = '0;
        if (pressPulse) begin
          w_next_state = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        if (releasePulse) begin
          w_next_state = ST_IDLE;
          w_next_count = '0;
        end else if (w_at_long) begin
          w_next_state = ST_REPEAT;
          w_next_count = '0;
        end else begin
          w_next_count = r_count + CNT_W'(1);
        end
      end
      ST_REPEAT: begin
        if (releasePulse) begin
          w_next_state = ST_IDLE;
          w_next_count = '0;
        end else if (w_at_repeat) begin
          w_next_count = '0;
        end else begin
          w_next_count = r_count + CNT_W'(1);
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_count = '0;
      end
    endcase
  end

  // Output decode: pulses are computed from the same conditions as the
  // transitions and registered alongside the state; held follows next state.
  always_comb begin
    w_next_short  = 1'b0;
    w_next_long   = 1'b0;
    w_next_repeat = 1'b0;
    w_next_held   = (w_next_state != ST_IDLE);
    unique case (r_state)
      ST_PRESSED: begin
        if (releasePulse) begin
          w_next_short = 1'b1;
        end else if (w_at_long) begin
          w_next_long = 1'b1;
        end
      end
      ST_REPEAT: begin
        // repeatEnable is sampled only here; the phase runs regardless.
        if (!releasePulse && w_at_repeat) begin
          w_next_repeat = repeatEnable;
        end
      end
      default: begin
      end
    endcase
  end

  assign shortPress  = r_short;
  assign longPress   = r_long;
  assign repeatPulse = r_repeat;
  assign held        = r_held;

endmodule
